// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit (muldiv_iter).
// Optional feature macro used by the top: MULDIV_EARLY_OUT_EN.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Upper half of the funct3 space is the divide/remainder group.
    function automatic logic is_div(input logic [2:0] f);
        return f[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] f);
        return (f == F3_MULH) || (f == F3_MULHSU) || (f == F3_DIV) || (f == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] f);
        return (f == F3_MULH) || (f == F3_DIV) || (f == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand conditioning for muldiv_iter: sign extraction and magnitude per funct3.
// Purely combinational; the top registers the outputs when an op is accepted.
module muldiv_operand_prep import muldiv_pkg::*; (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            sign_a,
    output logic            sign_b,
    output logic            b_zero
);

    // Magnitudes stay XLEN wide: -0x80000000 wraps back to 0x80000000, which is
    // exactly the unsigned magnitude.
    always_comb begin
        sign_a = is_signed_a(funct3) & a[XLEN-1];
        sign_b = is_signed_b(funct3) & b[XLEN-1];
        a_mag  = sign_a ? (~a + 1'b1) : a;
        b_mag  = sign_b ? (~b + 1'b1) : b;
        b_zero = (b == '0);
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 RV32M multiply/divide unit feeding the register file write port.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and multiply
// by zero bypass the 32 iteration cycles (IDLE -> FIX -> DONE).
module muldiv_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            wer
);
    import muldiv_pkg::*;

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] CALC = ST_CALC;
    localparam logic [1:0] FIX  = ST_FIX;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]        state;
    logic              pend;       // operands captured, datapath not yet started
    logic [2:0]        op;
    logic              sign_a_q, sign_b_q, b_zero_q, early_q;
    logic [XLEN-1:0]   a_mag_q, b_mag_q;
    logic [2*XLEN-1:0] acc;        // mul: {hi, multiplier}; div: {rem, quo}
    logic [CNT_W-1:0]  cnt;

    logic [XLEN-1:0]   a_mag, b_mag;
    logic              sign_a, sign_b, b_zero;
    logic              accept, early_hit;

    muldiv_operand_prep u_prep (
        .funct3 (funct3),
        .a      (rs1_val),
        .b      (rs2_val),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .sign_a (sign_a),
        .sign_b (sign_b),
        .b_zero (b_zero)
    );

    assign accept = (state == IDLE) && !pend && start && !flush;

`ifdef MULDIV_EARLY_OUT_EN
    // Detect operand patterns whose result needs no iteration.
    always_comb begin
        if (is_div(funct3))
            early_hit = b_zero ||
                        (is_signed_a(funct3) && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                         (rs2_val == '1));
        else
            early_hit = (rs1_val == '0) || b_zero;
    end
`else
    assign early_hit = 1'b0;
`endif

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN+1:0]   div_trial;
    logic [2*XLEN-1:0] acc_step;

    // One radix-2 step: shift-add for multiply, restoring trial subtract for divide.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // unassigned and a latch cannot be inferred.
        acc_step  = acc;
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag_q} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_trial = {1'b0, div_shift} - {2'b00, b_mag_q};
        if (is_div(op)) begin
            if (!div_trial[XLEN+1])
                acc_step = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_step = {mul_sum, acc[XLEN-1:1]};
        end
    end

    logic              neg_ab;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fix_val;

    // Sign correction and result-word selection used in FIX.
    always_comb begin
        neg_ab = sign_a_q ^ sign_b_q;
        prod   = neg_ab ? -acc : acc;
        // Divide by zero always yields all ones, independent of the dividend sign.
        quo    = b_zero_q ? '1 : (neg_ab ? -acc[XLEN-1:0] : acc[XLEN-1:0]);
        rem    = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op)
            F3_MUL:                       fix_val = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_val = quo;
            default:                      fix_val = rem;
        endcase
    end

    // Control FSM plus operand, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order; the whole datapath is a
        // handful of registers, so all of it is reset.
        if (!rst_n) begin
            state    <= IDLE;
            pend     <= 1'b0;
            op       <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            early_q  <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            rd_out   <= '0;
        end else if (flush) begin
            state <= IDLE;
            pend  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The capture cycle lets the first step run from registered
                    // magnitudes instead of the register-file read path.
                    if (pend) begin
                        pend <= 1'b0;
                        if (early_q) begin
                            state <= FIX;
                            if (!is_div(op))
                                acc <= '0;
                            else if (b_zero_q)
                                acc <= {a_mag_q, {XLEN{1'b1}}};
                            else
                                acc <= {{XLEN{1'b0}}, a_mag_q};
                        end else begin
                            state <= CALC;
                            acc   <= {{XLEN{1'b0}}, a_mag_q};
                        end
                    end else if (accept) begin
                        pend     <= 1'b1;
                        op       <= funct3;
                        rd_out   <= rd_in;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        b_zero_q <= b_zero;
                        early_q  <= early_hit;
                        a_mag_q  <= a_mag;
                        b_mag_q  <= b_mag;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITERS - 1))
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_val;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = pend || (state == CALC) || (state == FIX);
    assign done = (state == DONE) && !flush;
    assign wer  = done;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: the driver queues expected results, an
// independent monitor pops and compares on every done pulse.
module tb_muldiv_iter;
    import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, wer;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_iter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out),
        .wer     (wer)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            check("done_single_cycle", 32'(done_prev), 32'd0);
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("rd_out", 32'(rd_out), 32'(e.rd));
                check("wer", 32'(wer), 32'd1);
                check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
            end
        end
        done_prev <= done;
    end

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #3;
            if (sb.size() == 0) break;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rd, input bit early);
        exp_t e;
        e.res     = res;
        e.rd      = rd;
        e.acc_cyc = cyc;
        e.lat     = (early && EARLY) ? 2 : 34;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input bit early);
        @(negedge clk);
        start   = 1'b1;
        funct3  = f;
        rs1_val = a;
        rs2_val = b;
        rd_in   = rd;
        @(posedge clk);
        #1;
        push_exp(res, rd, early);
        check("busy_after_start", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wer", 32'(wer), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors: funct3, a, b, rd, expected result, early-out eligible
        issue(F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
        issue(F3_MULH,   32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000, 1'b0);
        issue(F3_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1'b0);
        issue(F3_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h7FFF_FFFF, 1'b0);
        issue(F3_MUL,    32'h1234_5678, 32'h0000_0010, 5'd9,  32'h2345_6780, 1'b0);
        issue(F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD, 1'b0);
        issue(F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, 1'b0);
        issue(F3_DIVU,   32'hFFFF_FFFF, 32'h0000_0002, 5'd12, 32'h7FFF_FFFF, 1'b0);
        issue(F3_REMU,   32'h0000_0064, 32'h0000_0007, 5'd13, 32'h0000_0002, 1'b0);
        issue(F3_DIV,    32'h1234_5678, 32'h0000_0000, 5'd14, 32'hFFFF_FFFF, 1'b1);
        issue(F3_DIVU,   32'h1234_5678, 32'h0000_0000, 5'd15, 32'hFFFF_FFFF, 1'b1);
        issue(F3_REM,    32'h1234_5678, 32'h0000_0000, 5'd16, 32'h1234_5678, 1'b1);
        issue(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1'b1);
        issue(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, 1'b1);
        issue(F3_MUL,    32'h0000_0005, 32'h0000_0000, 5'd0,  32'h0000_0000, 1'b1);

        // Back-to-back: a start held through the DONE cycle is taken only in IDLE.
        @(negedge clk);
        start = 1'b1; funct3 = F3_MULHU; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF; rd_in = 5'd20;
        @(posedge clk);
        #1;
        push_exp(32'hFFFF_FFFE, 5'd20, 1'b0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) break;
        end
        check("b2b_first_done", 32'(done), 32'd1);
        start = 1'b1; funct3 = F3_DIVU; rs1_val = 32'h0000_0064; rs2_val = 32'h0000_0007; rd_in = 5'd21;
        @(posedge clk);
        #1;
        check("b2b_start_in_done_ignored", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        push_exp(32'h0000_000E, 5'd21, 1'b0);
        check("b2b_start_in_idle_taken", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Flush during CALC at counter=10: no writeback, busy drops on the flush edge.
        @(negedge clk);
        start = 1'b1; funct3 = F3_DIVU; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h0000_0003; rd_in = 5'd22;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        check("busy_before_flush", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_flush", 32'(busy), 32'd0);
        check("result_kept_after_flush", result, 32'h0000_000E);
        @(negedge clk);
        flush = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of an op.
        start = 1'b1; funct3 = F3_MUL; rs1_val = 32'h0000_0003; rs2_val = 32'h0000_0004; rd_in = 5'd23;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("busy_on_reset", 32'(busy), 32'd0);
        check("result_on_reset", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Normal operation resumes after flush and reset.
        issue(F3_MUL, 32'h0000_0006, 32'h0000_0007, 5'd24, 32'h0000_002A, 1'b0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide execute unit. Sits directly downstream of the register file.
- Consumes rv1/rv2 and the decoded rd/funct3.
- Returns a result plus a one-cycle write strobe that drives the register file's regdata/rd/wer write port.
- Radix-2 engine: one product or quotient bit per clock. The CPU stalls on busy.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- flush  input  1  abort the in-flight op; no writeback
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1_val  input  32  operand a (register file rv1)
- rs2_val  input  32  operand b (register file rv2)
- rd_in  input  5  destination register
- busy  output  1  op in flight; start is ignored
- done  output  1  one-cycle result-valid pulse
- result  output  32  result; held stable until the next accepted start
- rd_out  output  5  destination captured at start
- wer  output  1  equals done; drives the register file write enable

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, wer=0, result=0, rd_out=0; counter and accumulators cleared.
  - Reset mid-operation discards the op; there is no write.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE, start=1, flush=0, at edge E:
  - latch funct3, rd_in, sign flags, and magnitudes |a| and |b|, where signedness is decided per funct3;
  - counter=0, busy=1.
- CALC, 32 cycles, counter 0..31:
  - Multiply: shift-add on a 64-bit unsigned accumulator.
  - Divide: restoring step. Shift {rem,quo} left, trial-subtract |b|, set the quotient bit if no borrow.
  - At counter=31, go to FIX.
- FIX, 1 cycle: apply signs.
  - Product is negated if sign_a ^ sign_b.
  - Quotient is negated if sign_a ^ sign_b.
  - Remainder takes sign_a.
  - Select the low word (MUL), the high word (MULH/MULHSU/MULHU), the quotient or the remainder into result.
- DONE, 1 cycle: done=1, wer=1, busy=0 in this cycle. Next state is IDLE.
  - Latency: done is high in the cycle after edge E+34.
  - Back-to-back: a start sampled during DONE is ignored. The next start is accepted one cycle later, in IDLE.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: low word, sign-agnostic.
- Divide by zero (b=0): quotient=0xFFFFFFFF for both DIV and DIVU; remainder=a. No trap.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM gives 0.
  - Magnitude 0x80000000 must be held in 32 bits unsigned without loss.
- flush has priority over everything. In CALC/FIX/DONE it returns to IDLE next edge with done=0 and no wer; result is unchanged.
  - flush and start together in IDLE: start is ignored.
- rd_out=0 still produces wer=1; the register file discards x0 writes.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: these cases skip CALC and go IDLE -> FIX -> DONE, with done in the cycle after edge E+2:
  - divide by zero;
  - signed overflow;
  - multiply with either operand zero.
  - Results are identical to the non-early path.
- Undefined: every op takes the full 34-cycle latency.

Decomposition:
- Package muldiv_pkg holds:
  - XLEN;
  - a funct3 enum (MUL..REMU);
  - a state enum (IDLE, CALC, FIX, DONE);
  - constant ITERS=32;
  - helper functions is_div(funct3), is_signed_a(funct3), is_signed_b(funct3).
- One natural sub-module, muldiv_operand_prep: combinational abs value and sign extraction for a and b per funct3. Top holds the FSM and datapath.

Test Plan:
- MUL 7 x -3 (0x00000007, 0xFFFFFFFD), rd=5 -> done in the cycle after edge E+34; result=0xFFFFFFEB, rd_out=5, wer=1 for 1 cycle.
- MULH/MULHSU/MULHU with a=0x80000000, b=0xFFFFFFFF -> results 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- DIV/DIVU/REM x/0 with x=0x12345678 -> quotient 0xFFFFFFFF, remainder 0x12345678. With MULDIV_EARLY_OUT_EN, done 2 cycles after start.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
- Start DIVU, flush at CALC counter=10, then rst_n pulsed low during a second op:
  - no done/wer for either op;
  - busy drops on the next edge after flush, and immediately on reset;
  - the next start completes normally.
